vend_sequencer: RTL and testbench

- Central controller for a two-product vending unit.
- Accumulates coin credit in 5-rs units and arbitrates selection against price.
- Sequences the product dispenser through a req/ack handshake, then drives the coin hopper one 5-rs unit at a time to return change.
- Sits between the coin acceptor/keypad front end and the dispenser/hopper actuators.

---
 rtl/vend_sequencer.sv | 169 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Central controller for a two-product vending unit: accumulates coin credit in 5-rs units,
// hands a paid selection to the dispenser over req/ack, then pays change out through the hopper.
module vend_sequencer #(
  parameter int PRICE_A      = 3,
  parameter int PRICE_B      = 4,
  parameter int MAX_CREDIT   = 8,
  parameter int VEND_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       vend_ack,
  input  logic       hopper_ack,
  output logic       coin_reject,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       change_req,
  output logic       vend_fault,
  output logic [3:0] credit,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [3:0] L_PRICE_A = 4'(PRICE_A);
  localparam logic [3:0] L_PRICE_B = 4'(PRICE_B);
  localparam logic [4:0] L_MAX     = 5'(MAX_CREDIT);
  localparam logic [7:0] L_TO_LAST = 8'(VEND_TIMEOUT - 1);

  state_t     r_state;
  logic [3:0] r_credit;
  logic [3:0] r_price;
  logic [7:0] r_timer;
  logic       r_coin_reject;
  logic       r_vend_req;
  logic [1:0] r_vend_item;
  logic       r_change_req;
  logic       r_vend_fault;
  logic       r_busy;

  logic       w_coin_valid;
  logic [3:0] w_coin_val;
  logic [4:0] w_coin_sum;
  logic       w_sel_valid;
  logic [3:0] w_sel_price;
  logic       w_front;
  logic       w_coin_ok;

  always_comb begin
    w_coin_val = 4'd0;
    case (coin)
      2'b01:   w_coin_val = 4'd1;
      2'b10:   w_coin_val = 4'd2;
      default: w_coin_val = 4'd0;
    endcase
  end

  // A coin is credited only at the front desk and only when nothing of higher priority shares its cycle.
  assign w_coin_valid = (coin == 2'b01) || (coin == 2'b10);
  assign w_coin_sum   = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_sel_valid  = (sel == 2'b01) || (sel == 2'b10);
  assign w_sel_price  = (sel == 2'b01) ? L_PRICE_A : L_PRICE_B;
  assign w_front      = (r_state == S_IDLE) || (r_state == S_CREDIT);
  assign w_coin_ok    = w_front && w_coin_valid && !cancel && !w_sel_valid &&
                        (w_coin_sum <= L_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_credit      <= 4'd0;
      r_price       <= 4'd0;
      r_timer       <= 8'd0;
      r_coin_reject <= 1'b0;
      r_vend_req    <= 1'b0;
      r_vend_item   <= 2'b00;
      r_change_req  <= 1'b0;
      r_vend_fault  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_coin_reject <= (coin != 2'b00) && !w_coin_ok;
      r_vend_fault  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_coin_ok) begin
            r_credit <= w_coin_sum[3:0];
            r_state  <= S_CREDIT;
          end
        end
        S_CREDIT: begin
          if (cancel) begin
            r_state      <= S_CHANGE;
            r_change_req <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_sel_valid) begin
            if (r_credit >= w_sel_price) begin
              r_credit    <= r_credit - w_sel_price;
              r_price     <= w_sel_price;
              r_vend_item <= sel;
              r_vend_req  <= 1'b1;
              r_timer     <= 8'd0;
              r_busy      <= 1'b1;
              r_state     <= S_VEND;
            end
          end else if (w_coin_ok) begin
            r_credit <= w_coin_sum[3:0];
          end
        end
        S_VEND: begin
          if (vend_ack) begin
            r_vend_req  <= 1'b0;
            r_vend_item <= 2'b00;
            r_timer     <= 8'd0;
            if (r_credit != 4'd0) begin
              r_state      <= S_CHANGE;
              r_change_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_timer == L_TO_LAST) begin
            // Dispenser never answered: give the customer back the whole price.
            r_vend_fault <= 1'b1;
            r_credit     <= r_credit + r_price;
            r_vend_req   <= 1'b0;
            r_vend_item  <= 2'b00;
            r_timer      <= 8'd0;
            r_change_req <= 1'b1;
            r_state      <= S_CHANGE;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_CHANGE: begin
          if (r_credit == 4'd0) begin
            r_change_req <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else if (hopper_ack) begin
            r_credit <= r_credit - 4'd1;
            if (r_credit == 4'd1) begin
              r_change_req <= 1'b0;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_reject = r_coin_reject;
  assign vend_req    = r_vend_req;
  assign vend_item   = r_vend_item;
  assign change_req  = r_change_req;
  assign vend_fault  = r_vend_fault;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the vending rules.
module tb_vend_sequencer;

  localparam int PA   = 3;
  localparam int PB   = 4;
  localparam int MAXC = 8;
  localparam int TMO  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin = 2'b00;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       vend_ack = 1'b0;
  logic       hopper_ack = 1'b0;
  logic       coin_reject;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       change_req;
  logic       vend_fault;
  logic [3:0] credit;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: credit as an integer plus "dispensing" / "paying out" flags.
  int         m_credit;
  int         m_wait;
  int         m_price;
  bit         m_disp;
  bit         m_pay;
  bit         m_reject;
  bit         m_fault;
  logic [1:0] m_item;

  vend_sequencer #(
    .PRICE_A(PA), .PRICE_B(PB), .MAX_CREDIT(MAXC), .VEND_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .vend_ack(vend_ack), .hopper_ack(hopper_ack), .coin_reject(coin_reject),
    .vend_req(vend_req), .vend_item(vend_item), .change_req(change_req),
    .vend_fault(vend_fault), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [6:0] st(input logic [1:0] c, input logic [1:0] s,
                                    input logic cn, input logic va, input logic ha);
    return {c, s, cn, va, ha};
  endfunction

  function automatic logic [10:0] obs();
    return {coin_reject, vend_req, vend_item, change_req, vend_fault, credit, busy};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic [1:0] item;
    item = m_disp ? m_item : 2'b00;
    return {m_reject, m_disp, item, (m_pay && m_credit > 0), m_fault, 4'(m_credit),
            (m_disp || m_pay)};
  endfunction

  task automatic model_reset();
    m_credit = 0; m_wait = 0; m_price = 0;
    m_disp = 0; m_pay = 0; m_reject = 0; m_fault = 0; m_item = 2'b00;
  endtask

  task automatic model_update(input logic [6:0] s);
    logic [1:0] c, sl;
    logic cn, va, ha;
    int val, price;
    bit selv, front;
    {c, sl, cn, va, ha} = s;
    val   = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    selv  = (sl == 2'b01) || (sl == 2'b10);
    price = (sl == 2'b01) ? PA : PB;
    front = !m_disp && !m_pay;
    m_fault  = 0;
    m_reject = (c != 2'b00) &&
               !(front && val > 0 && !cn && !selv && (m_credit + val <= MAXC));
    if (front) begin
      if (cn) begin
        if (m_credit > 0) m_pay = 1;
      end else if (selv) begin
        if (m_credit > 0 && m_credit >= price) begin
          m_credit -= price; m_price = price; m_item = sl; m_disp = 1; m_wait = 0;
        end
      end else if (val > 0 && m_credit + val <= MAXC) begin
        m_credit += val;
      end
    end else if (m_disp) begin
      if (va) begin
        m_disp = 0;
        if (m_credit > 0) m_pay = 1;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_fault = 1; m_credit += m_price; m_disp = 0; m_pay = 1;
        end
      end
    end else begin
      if (ha && m_credit > 0) begin
        m_credit--;
        if (m_credit == 0) m_pay = 0;
      end
    end
  endtask

  task automatic step(input logic [6:0] s);
    {coin, sel, cancel, vend_ack, hopper_ack} = s;
    @(posedge clk);
    #1;
    model_update(s);
    {coin, sel, cancel, vend_ack, hopper_ack} = 7'd0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs() !== 11'd0) begin
      n_fail++; $display("[TB] FAIL reset_state: got %b want %b", obs(), 11'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(st(2'b00, 2'b00, 0, 0, 0));
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL reset_release: got %b want %b", obs(), exp_vec());
    end
  endtask

  task automatic test_exact_vend();
    logic [6:0] seq[$];
    bit saw_change;
    saw_change = 0;
    seq.push_back(st(2'b10, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b01, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b01, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 1, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    foreach (seq[i]) begin
      step(seq[i]);
      if (change_req) saw_change = 1;
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL exact_vend[%0d]: got %b want %b", i, obs(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if ({vend_req, vend_item, credit} !== {1'b1, 2'b01, 4'd0}) begin
          n_fail++; $display("[TB] FAIL exact_vend_req: got %b want %b",
                             {vend_req, vend_item, credit}, {1'b1, 2'b01, 4'd0});
        end
      end
    end
    n_checks++;
    if (saw_change !== 1'b0) begin
      n_fail++; $display("[TB] FAIL exact_vend_no_change: got %b want 0", saw_change);
    end
  endtask

  task automatic test_vend_change();
    logic [6:0] seq[$];
    for (int k = 0; k < 3; k++) seq.push_back(st(2'b10, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b10, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 1, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 1));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 1));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL vend_change[%0d]: got %b want %b", i, obs(), exp_vec());
      end
      if (i == 3) begin
        n_checks++;
        if ({vend_req, vend_item, credit} !== {1'b1, 2'b10, 4'd2}) begin
          n_fail++; $display("[TB] FAIL vend_change_sel: got %b want %b",
                             {vend_req, vend_item, credit}, {1'b1, 2'b10, 4'd2});
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({change_req, vend_req} !== 2'b10) begin
          n_fail++; $display("[TB] FAIL vend_change_ack: got %b want 10", {change_req, vend_req});
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({credit, change_req, busy} !== 6'd0) begin
          n_fail++; $display("[TB] FAIL vend_change_done: got %b want 0", {credit, change_req, busy});
        end
      end
    end
  endtask

  task automatic test_overflow_reject();
    logic [6:0] seq[$];
    for (int k = 0; k < 4; k++) seq.push_back(st(2'b10, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b01, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b11, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b01, 0, 0, 0));
    seq.push_back(st(2'b10, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 1, 0));
    for (int k = 0; k < 5; k++) seq.push_back(st(2'b00, 2'b00, 0, 0, 1));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL overflow[%0d]: got %b want %b", i, obs(), exp_vec());
      end
      if (i == 4 || i == 5) begin
        n_checks++;
        if ({coin_reject, credit} !== {1'b1, 4'd8}) begin
          n_fail++; $display("[TB] FAIL overflow_reject[%0d]: got %b want %b",
                             i, {coin_reject, credit}, {1'b1, 4'd8});
        end
      end
      if (i == 7) begin
        n_checks++;
        if ({coin_reject, credit, vend_req} !== {1'b1, 4'd5, 1'b1}) begin
          n_fail++; $display("[TB] FAIL coin_in_vend: got %b want %b",
                             {coin_reject, credit, vend_req}, {1'b1, 4'd5, 1'b1});
        end
      end
    end
  endtask

  task automatic test_insufficient_cancel();
    logic [6:0] seq[$];
    seq.push_back(st(2'b10, 2'b00, 0, 0, 0));
    seq.push_back(st(2'b00, 2'b01, 0, 0, 0));
    seq.push_back(st(2'b01, 2'b00, 1, 0, 0));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 1));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 1));
    seq.push_back(st(2'b00, 2'b00, 0, 0, 0));
    foreach (seq[i]) begin
      step(seq[i]);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL cancel[%0d]: got %b want %b", i, obs(), exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if ({credit, vend_req, busy} !== {4'd2, 1'b0, 1'b0}) begin
          n_fail++; $display("[TB] FAIL insufficient_sel: got %b want %b",
                             {credit, vend_req, busy}, {4'd2, 1'b0, 1'b0});
        end
      end
      if (i == 2) begin
        n_checks++;
        if ({coin_reject, credit, change_req, busy} !== {1'b1, 4'd2, 1'b1, 1'b1}) begin
          n_fail++; $display("[TB] FAIL coin_with_cancel: got %b want %b",
                             {coin_reject, credit, change_req, busy}, {1'b1, 4'd2, 1'b1, 1'b1});
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({credit, change_req, busy} !== 6'd0) begin
          n_fail++; $display("[TB] FAIL refund_done: got %b want 0", {credit, change_req, busy});
        end
      end
    end
  endtask

  task automatic test_timeout();
    int fault_at;
    fault_at = -1;
    step(st(2'b10, 2'b00, 0, 0, 0));
    step(st(2'b01, 2'b00, 0, 0, 0));
    step(st(2'b00, 2'b01, 0, 0, 0));
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL timeout_start: got %b want %b", obs(), exp_vec());
    end
    for (int k = 1; k <= TMO + 3; k++) begin
      step(st(2'b00, 2'b00, 0, 0, 0));
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL timeout_wait[%0d]: got %b want %b", k, obs(), exp_vec());
      end
      if (vend_fault === 1'b1 && fault_at < 0) fault_at = k;
      if (fault_at > 0 && k > fault_at) break;
    end
    n_checks++;
    if (fault_at != TMO) begin
      n_fail++; $display("[TB] FAIL timeout_cycle: got %0d want %0d", fault_at, TMO);
    end
    n_checks++;
    if ({credit, change_req, vend_req, busy} !== {4'd3, 1'b1, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL timeout_refund: got %b want %b",
                         {credit, change_req, vend_req, busy}, {4'd3, 1'b1, 1'b0, 1'b1});
    end
    for (int k = 0; k < 3; k++) begin
      step(st(2'b00, 2'b00, 0, 0, 1));
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL timeout_payout[%0d]: got %b want %b", k, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(st(2'b10, 2'b00, 0, 0, 0));
    step(st(2'b10, 2'b00, 0, 0, 0));
    step(st(2'b00, 2'b00, 1, 0, 0));
    step(st(2'b00, 2'b00, 0, 0, 1));
    n_checks++;
    if (obs() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL pre_reset: got %b want %b", obs(), exp_vec());
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 11'd0) begin
      n_fail++; $display("[TB] FAIL async_reset: got %b want %b", obs(), 11'd0);
    end
    model_reset();
    #2 rst = 1'b1;
    step(st(2'b00, 2'b00, 0, 0, 1));
    step(st(2'b01, 2'b00, 0, 0, 0));
    n_checks++;
    if ({credit, busy, coin_reject} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL post_reset_coin: got %b want %b",
                         {credit, busy, coin_reject}, {4'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [1:0] c, s;
    logic cn, va, ha;
    for (int i = 0; i < 3000; i++) begin
      c  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 7) % 3 + 1);
      s  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cn = ($urandom_range(0, 19) == 0);
      va = ($urandom_range(0, 4) == 0);
      ha = ($urandom_range(0, 1) == 0);
      step(st(c, s, cn, va, ha));
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL random[%0d]: got %b want %b", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_overflow_reject();
    test_insufficient_cancel();
    test_timeout();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
